// File: rtl/mdu_pkg.sv
// Shared MDU op encodings, default latencies and op-class helpers.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic op_valid(input logic [3:0] op);
    logic v;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO: v = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU:                  v = 1'b1;
`endif
      default:                                                   v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic op_is_move(input logic [3:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational MDU datapath: product, quotient/remainder and HI/LO moves.
// MADD/MADDU/MSUB/MSUBU results are produced only when MDU_MADD_EN is defined.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        commit_en
);

  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Sign-extending to 64 bits makes the low 64 bits of the product correct for signed ops.
  always_comb begin
    mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
    a_ext      = mul_signed ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    b_ext      = mul_signed ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    prod       = a_ext * b_ext;
  end

  // Sign-magnitude divide: truncates toward zero, remainder follows the dividend.
  always_comb begin
    a_neg   = (op == MDU_DIV) && rs_val[31];
    b_neg   = (op == MDU_DIV) && rt_val[31];
    a_mag   = a_neg ? -rs_val : rs_val;
    b_mag   = b_neg ? -rt_val : rt_val;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    result    = {hi, lo};
    commit_en = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        result    = prod;
        commit_en = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        result    = {rem, quo};
        commit_en = (rt_val != 32'd0);
      end
      MDU_MTHI: begin
        result    = {rs_val, lo};
        commit_en = 1'b1;
      end
      MDU_MTLO: begin
        result    = {hi, rs_val};
        commit_en = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: begin
        result    = {hi, lo} + prod;
        commit_en = 1'b1;
      end
      MDU_MSUB, MDU_MSUBU: begin
        result    = {hi, lo} - prod;
        commit_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit owning architectural HI/LO with a multi-cycle busy window.
// MDU_MADD_EN adds the accumulate/subtract multiply ops (latency MULT_CYCLES).
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     hi_n_q, hi_n_d;
  logic [31:0]     lo_n_q, lo_n_d;
  logic            commit_q, commit_d;

  logic [63:0]     result;
  logic            commit_en;
  logic            accept;

  mdu_compute u_compute (
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hi       (hi_q),
    .lo       (lo_q),
    .result   (result),
    .commit_en(commit_en)
  );

  // A start during busy is dropped; a flushed or unknown op never touches state.
  assign accept = start && !req && !busy_q && op_valid(op);

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_n_d   = hi_n_q;
    lo_n_d   = lo_n_q;
    commit_d = commit_q;

    if (busy_q) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        // A divide by zero still occupies the unit but leaves HI/LO untouched.
        if (commit_q) begin
          hi_d = hi_n_q;
          lo_d = lo_n_q;
        end
      end
    end else if (accept) begin
      if (op_is_move(op)) begin
        {hi_d, lo_d} = result;
      end else begin
        {hi_n_d, lo_n_d} = result;
        commit_d         = commit_en;
        busy_d           = 1'b1;
        cnt_d            = op_is_div(op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_n_q   <= '0;
      lo_n_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_n_q   <= hi_n_d;
      lo_n_q   <= lo_n_d;
      commit_q <= commit_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the architectural HI/LO registers and runs multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
- Drives the hi/lo values that the W-stage GRF write-data mux selects for MFHI/MFLO.
- Exposes busy so the hazard unit can stall any HI/LO-touching instruction in D.

Parameters:
- MULT_CYCLES, 5, busy duration of a multiply (>=1).
- DIV_CYCLES, 10, busy duration of a divide (>=1).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous reset, active-low.
- start  input  1  E-stage instruction is an MDU op this cycle (single-cycle pulse per instruction).
- op  input  4  MDU operation code (package encoding).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- req  input  1  exception/interrupt flush from CP0; suppresses the op presented in the same cycle.
- busy  output  1  an operation is in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (reset==0 at a rising edge): hi=0, lo=0, busy=0, counter=0, shadow registers=0. Applies mid-operation and discards the in-flight op.
- An op is accepted when start=1, req=0, busy=0 and op is a valid code. Otherwise the request is ignored and no state changes.
- Hazard unit guarantees no start while busy. Defensively, a start while busy is dropped.
- MTHI/MTLO:
  - hi<=rs_val (or lo<=rs_val) at the same edge.
  - busy stays 0.
  - Zero latency; the new value is visible on hi/lo the next cycle.
- MULT/MULTU:
  - The 64-bit product of rs_val and rt_val (signed or unsigned) is latched into shadow hi_n/lo_n at the accept edge.
  - counter<=MULT_CYCLES and busy<=1.
- DIV/DIVU:
  - lo_n=quotient, hi_n=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo_n=0x80000000, hi_n=0.
  - counter<=DIV_CYCLES and busy<=1.
- Divide by zero (rt_val==0): busy for DIV_CYCLES as normal; hi/lo stay unchanged at commit.
- While busy:
  - counter decrements each cycle.
  - On the edge where counter goes 1->0: hi<=hi_n, lo<=lo_n, busy<=0.
  - Net effect: busy is high for exactly N cycles starting the cycle after the accept. The new hi/lo are visible in the cycle busy falls.
- hi/lo never change during busy. Reads during busy return the old values; the hazard unit must stall MFHI/MFLO on start|busy.
- req while busy has no effect: the in-flight op is older than the faulting instruction and completes.
- State machine:
  - IDLE -> MUL_BUSY or DIV_BUSY on accept.
  - MUL_BUSY/DIV_BUSY -> IDLE on commit.
  - Any state -> IDLE on reset.
  - The state is fully encoded by busy plus the counter.

Optional Feature:
- Macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
- With the macro defined:
  - Shadow result = {hi,lo} +/- the 64-bit signed/unsigned product, sampled at accept; wraps mod 2^64.
  - Latency is MULT_CYCLES.
- Without the macro: those codes are invalid and ignored (no busy, no state change).

Decomposition:
- Package mdu_pkg holds:
  - the op encodings: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MADD=7, MDU_MADDU=8, MDU_MSUB=9, MDU_MSUBU=10;
  - the default latency constants.
- One sub-module, mdu_compute: purely combinational. Takes op, operands and current hi/lo; returns the 64-bit shadow result and a commit-enable flag (0 for divide-by-zero and invalid ops).
- The top level holds the counter, busy, shadows and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 in consecutive cycles -> hi/lo update the next cycle each, busy stays 0.
- DIV with rt=0 after hi=0xAAAA, lo=0x5555 -> busy 10 cycles, hi/lo unchanged. Signed 0x80000000 / -1 -> lo=0x80000000, hi=0.
- start=1 with req=1 (MULT 3*4) -> no busy, hi/lo unchanged. reset=0 in cycle 3 of a DIV -> hi=lo=0, busy=0 next cycle, nothing committed later.
- With MDU_MADD_EN: hi=0, lo=10, MADD 3*4 -> lo=22 after 5 cycles. MSUB 5*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD. Without the macro, MADD is ignored.
